ascon_aead128a_core: RTL and testbench
======================================

Name: ascon_aead128a_core

Overview:
- Ascon-128a authenticated-encryption engine: 128-bit key, nonce, rate and tag; 12-round initialisation and finalisation, 8-round intermediate permutation.
- Computes one permutation round per clock.
- Accepts pre-padded 128-bit associated-data (AD) and text blocks over a req/ack input handshake.
- Returns ciphertext/plaintext blocks and the final tag over a req/ack output handshake.
- Sits between a host-side block sequencer and the crypto datapath; tag comparison on decrypt is external.

Parameters:
- IV, 64'h80800c0800000000, Ascon-128a initial value (k=128, r=128, a=12, b=8).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  synchronous, active-low reset.
- key  in  128  secret key, big-endian (key[127:120] = byte 0); sampled at start.
- nonce  in  128  nonce, big-endian; sampled at start.
- start  in  1  begin a new message; honoured only in IDLE.
- encrypt  in  1  1 = encrypt, 0 = decrypt; latched at start.
- Din  in  128  input block (AD or text), already padded by the caller.
- dinReq  in  1  level request: Din, sel_data and last_block are valid.
- dinAck  out  1  one-cycle pulse: block accepted.
- sel_data  in  1  0 = AD block, 1 = text block.
- last_block  in  1  block is the last of its type.
- Dout  out  128  output text block or tag.
- doReq  out  1  Dout valid; held until doAck.
- doAck  in  1  consumer accepts Dout; may be combinationally tied to doReq.
- busy  out  1  high from start accept until the finished pulse.
- finished  out  1  one-cycle pulse after tag handshake completes.

Behaviour:
- One clock domain. Reset is synchronous and active-low.
- When rstn=0 at a clock edge (including mid-operation): go to IDLE, state regs 0, dinAck=0, doReq=0, Dout=0, busy=0, finished=0.
- State words: x0..x4, 64 bits each. Din[127:64] pairs with x0; Din[63:0] pairs with x1.
- Round: add constant to x2 (constants 0xf0,0xe1,..,0x4b; 12-round uses all 12, 8-round uses the last 8 starting 0xb4), 5-bit S-box layer, linear layer with rotations (19,28),(61,39),(1,6),(10,17),(7,41).
- IDLE:
  - On start=1, load x0=IV, x1x2=key, x3x4=nonce; latch key and encrypt; busy<=1; go to INIT.
  - dinReq is ignored in IDLE.
- INIT: 12 rounds (12 cycles), then x3x4 ^= key, go to WAIT_DIN.
- WAIT_DIN:
  - While dinReq=0, remain in WAIT_DIN.
  - When dinReq=1, pulse dinAck for exactly one cycle and capture Din, sel_data and last_block.
  - dinReq is ignored everywhere except WAIT_DIN, so a request still high the cycle after the ack is not re-accepted.
- AD block (sel_data=0):
  - x0x1 ^= Din, then 8 rounds.
  - If last_block=1, after the rounds apply x4 ^= 1 (domain separation) and mark AD done.
  - Return to WAIT_DIN.
- First text block with no AD processed: apply x4 ^= 1 first, then handle the block as a text block.
- Text block (sel_data=1):
  - Compute O = x0x1 ^ Din. Encrypt: x0x1 <= O. Decrypt: x0x1 <= Din.
  - Next cycle: Dout=O, doReq=1, held stable until doAck=1.
  - doReq falls the cycle after the ack.
  - If last_block=0: run 8 rounds, then return to WAIT_DIN.
  - If last_block=1: go to FINAL.
- All blocks are full 128-bit; partial-block handling is the caller's job via padding.
- FINAL:
  - x2x3 ^= key, 12 rounds.
  - Dout = (x3x4) ^ key, doReq=1 until doAck.
  - On the cycle after the ack: finished=1 for one cycle, busy<=0, go to IDLE.
- start while busy is ignored.
- The core always emits the tag; on decrypt the host compares it.

Test Plan:
- Reset: hold rstn=0 for 10 cycles → dinAck, doReq, busy and finished are 0 and Dout=0. Assert start with rstn=0 → no effect.
- Encrypt, key=nonce=000102..0f, one AD block 000102..0f, one padded AD last block 80000..0, one text block 000102..0f, padded last text block 8000..0, doAck tied to doReq → exactly 4 dinAck pulses; 2 ciphertext blocks and tag bit-exact to the golden Ascon-128a model; finished pulses once; busy low afterwards.
- Decrypt round-trip: feed the ciphertexts from the encrypt scenario with encrypt=0 → Dout returns 000102..0f and 8000..0; tag equals the encrypt tag.
- Protocol robustness:
  - dinReq held high one cycle past dinAck → no double accept.
  - doAck delayed 5 cycles → Dout and doReq held stable.
  - start pulsed mid-message → ignored.
- No AD: first block is a last text block → x4 domain bit is applied; results match the golden model for empty AD.
- Reset mid-permutation, then a fresh start → result identical to a clean run.

Source files
------------

// File: rtl/ascon_aead128a_core.sv
// Ascon-128a AEAD engine: one permutation round per clock, pre-padded 128-bit
// AD/text blocks in over req/ack, text blocks and the final tag out over req/ack.
module ascon_aead128a_core #(
  parameter logic [63:0] IV = 64'h80800c0800000000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic         start,
  input  logic         encrypt,
  input  logic [127:0] Din,
  input  logic         dinReq,
  output logic         dinAck,
  input  logic         sel_data,
  input  logic         last_block,
  output logic [127:0] Dout,
  output logic         doReq,
  input  logic         doAck,
  output logic         busy,
  output logic         finished
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT, S_PERM8, S_TEXT_OUT, S_FINAL, S_TAG_OUT
  } state_t;

  state_t       r_state, w_next;
  logic [319:0] r_x;
  logic [127:0] r_key, r_dout;
  logic [3:0]   r_rnd;
  logic         r_enc, r_sel, r_last, r_ad_done;
  logic         r_dinAck, r_doReq, r_busy, r_finished;

  logic [319:0] w_round;
  logic [127:0] w_o;
  logic         w_rnd_last, w_load, w_accept, w_hs;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // idx 0..11 selects constant 0xf0..0x4b; 8-round permutations start at idx 4
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
    x2 = x2 ^ {56'd0, 4'hf - idx, idx};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign w_round    = ascon_round(r_x, r_rnd);
  assign w_o        = r_x[319:192] ^ Din;
  assign w_rnd_last = (r_rnd == 4'd11);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_INIT;
      S_INIT:     if (w_rnd_last) w_next = S_WAIT;
      S_WAIT:     if (dinReq) w_next = sel_data ? S_TEXT_OUT : S_PERM8;
      S_PERM8:    if (w_rnd_last) w_next = S_WAIT;
      S_TEXT_OUT: if (doAck) w_next = r_last ? S_FINAL : S_PERM8;
      S_FINAL:    if (w_rnd_last) w_next = S_TAG_OUT;
      S_TAG_OUT:  if (doAck) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load   = (r_state == S_IDLE) && start;
    w_accept = (r_state == S_WAIT) && dinReq;
    w_hs     = ((r_state == S_TEXT_OUT) || (r_state == S_TAG_OUT)) && doAck;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_x <= '0; r_key <= '0; r_dout <= '0; r_rnd <= '0;
      r_enc <= 1'b0; r_sel <= 1'b0; r_last <= 1'b0; r_ad_done <= 1'b0;
      r_dinAck <= 1'b0; r_doReq <= 1'b0; r_busy <= 1'b0; r_finished <= 1'b0;
    end else begin
      r_dinAck   <= w_accept;
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE: if (w_load) begin
          r_x <= {IV, key, nonce};
          r_key <= key; r_enc <= encrypt; r_busy <= 1'b1;
          r_rnd <= 4'd0; r_ad_done <= 1'b0;
        end
        S_INIT: begin
          r_rnd <= r_rnd + 4'd1;
          r_x   <= w_rnd_last ? {w_round[319:128], w_round[127:0] ^ r_key} : w_round;
        end
        S_WAIT: if (w_accept) begin
          r_sel <= sel_data; r_last <= last_block; r_rnd <= 4'd4;
          if (!sel_data) begin
            r_x[319:192] <= w_o;
          end else begin
            r_dout <= w_o; r_doReq <= 1'b1;
            r_x[319:192] <= r_enc ? w_o : Din;
            // Empty AD: domain separation still precedes the first text block
            if (!r_ad_done) begin
              r_x[63:0] <= r_x[63:0] ^ 64'd1;
              r_ad_done <= 1'b1;
            end
          end
        end
        S_PERM8: begin
          r_rnd <= r_rnd + 4'd1;
          if (w_rnd_last && r_last && !r_sel) begin
            r_x <= w_round ^ 320'd1;
            r_ad_done <= 1'b1;
          end else begin
            r_x <= w_round;
          end
        end
        S_TEXT_OUT: if (w_hs) begin
          r_doReq <= 1'b0;
          r_rnd <= r_last ? 4'd0 : 4'd4;
          if (r_last) r_x[191:64] <= r_x[191:64] ^ r_key;
        end
        S_FINAL: begin
          r_rnd <= r_rnd + 4'd1;
          r_x   <= w_round;
          if (w_rnd_last) begin
            r_dout <= w_round[127:0] ^ r_key;
            r_doReq <= 1'b1;
          end
        end
        S_TAG_OUT: if (w_hs) begin
          r_doReq <= 1'b0; r_finished <= 1'b1; r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dinAck   = r_dinAck;
  assign Dout     = r_dout;
  assign doReq    = r_doReq;
  assign busy     = r_busy;
  assign finished = r_finished;

endmodule

// File: tb/tb_ascon_aead128a_core.sv
// Bench for ascon_aead128a_core: directed and random messages checked against
// a table-driven Ascon-128a reference model.
module tb_ascon_aead128a_core;

  localparam logic [63:0] IV = 64'h80800c0800000000;
  localparam logic [127:0] SEQ = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PAD = 128'h80000000000000000000000000000000;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, start, encrypt, dinReq, sel_data, last_block, ack_drv;
  logic [127:0] key, nonce, Din;
  logic [127:0] Dout;
  logic         dinAck, doReq, doAck, busy, finished;
  bit           tie;

  assign doAck = tie ? doReq : ack_drv;

  ascon_aead128a_core dut (
    .clk(clk), .rstn(rstn), .key(key), .nonce(nonce), .start(start),
    .encrypt(encrypt), .Din(Din), .dinReq(dinReq), .dinAck(dinAck),
    .sel_data(sel_data), .last_block(last_block), .Dout(Dout),
    .doReq(doReq), .doAck(doAck), .busy(busy), .finished(finished)
  );

  int n_total = 0, n_bad = 0;
  int ack_cnt = 0, fin_cnt = 0;
  logic [127:0] obs_q[$], exp_q[$], got_q[$];
  logic [127:0] ad_a[8], tx_a[8];

  always @(posedge clk) begin
    ack_cnt <= ack_cnt + int'(dinAck);
    fin_cnt <= fin_cnt + int'(finished);
    if (rstn && doReq && doAck) obs_q.push_back(Dout);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] st, input int nr);
    logic [63:0] x[5];
    logic [4:0]  v;
    for (int i = 0; i < 5; i++) x[i] = st[319 - 64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] ^= 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        v = SBOX[v];
        x[0][b] = v[4]; x[1][b] = v[3]; x[2][b] = v[2]; x[3][b] = v[1]; x[4][b] = v[0];
      end
      x[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
      x[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
      x[2] = x[2] ^ rr(x[2], 1)  ^ rr(x[2], 6);
      x[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
      x[4] = x[4] ^ rr(x[4], 7)  ^ rr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic model(input bit enc, input int nad, input int ntx);
    logic [319:0] s;
    logic [127:0] o;
    exp_q.delete();
    s = {IV, key, nonce};
    s = m_perm(s, 12);
    s[127:0] ^= key;
    for (int i = 0; i < nad; i++) begin
      s[319:192] ^= ad_a[i];
      s = m_perm(s, 8);
    end
    s[0] ^= 1'b1;
    for (int i = 0; i < ntx; i++) begin
      o = s[319:192] ^ tx_a[i];
      exp_q.push_back(o);
      s[319:192] = enc ? o : tx_a[i];
      if (i < ntx - 1) s = m_perm(s, 8);
    end
    s[191:64] ^= key;
    s = m_perm(s, 12);
    exp_q.push_back(s[127:0] ^ key);
  endtask

  task automatic get_out(input int dly);
    int n;
    logic [127:0] d0;
    n = 0;
    while (!doReq && n < 200) begin @(negedge clk); n++; end
    if (!doReq) begin chk("doreq_timeout", 0, 1); return; end
    d0 = Dout;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("hold_doreq", doReq, 1);
      chk("hold_dout", Dout, d0);
    end
    ack_drv = 1'b1;
    @(negedge clk);
    ack_drv = 1'b0;
    chk("doreq_fall", doReq, 0);
  endtask

  task automatic run_msg(input bit enc, input int nad, input int ntx, input bit hold,
                         input int dly, input bit smid, input bit tie_mode);
    int obs0, a0, f0, nb, n;
    bit sel;
    logic [127:0] g;
    model(enc, nad, ntx);
    tie = tie_mode; ack_drv = 1'b0;
    obs0 = obs_q.size(); a0 = ack_cnt; f0 = fin_cnt;
    nb = nad + ntx;
    @(negedge clk); encrypt = enc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_start", busy, 1);
    for (int b = 0; b < nb; b++) begin
      sel = (b >= nad);
      sel_data = sel;
      last_block = sel ? (b == nb - 1) : (b == nad - 1);
      Din = sel ? tx_a[b - nad] : ad_a[b];
      dinReq = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!dinAck && n < 200);
      if (!dinAck) begin chk("dinack_timeout", 0, 1); dinReq = 1'b0; return; end
      if (hold) @(negedge clk);
      dinReq = 1'b0;
      if (b == 0 && smid) begin
        start = 1'b1; encrypt = !enc;
        @(negedge clk);
        start = 1'b0; encrypt = enc;
      end
      if (sel && !tie) get_out(dly);
    end
    if (!tie) get_out(dly);
    n = 0;
    while (fin_cnt == f0 && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("finished_once", 128'(fin_cnt - f0), 1);
    chk("dinack_count", 128'(ack_cnt - a0), 128'(nb));
    chk("busy_end", busy, 0);
    chk("out_count", 128'(obs_q.size() - obs0), 128'(ntx + 1));
    got_q.delete();
    for (int i = 0; i <= ntx; i++) begin
      g = (obs0 + i < obs_q.size()) ? obs_q[obs0 + i] : 'x;
      chk(i == ntx ? "tag" : "dout", g, exp_q[i]);
      got_q.push_back(g);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic [127:0] ct0, ct1, tag_e;
    rstn = 1'b0; start = 1'b1; encrypt = 1'b1; dinReq = 1'b0; sel_data = 1'b0;
    last_block = 1'b0; ack_drv = 1'b0; tie = 1'b1;
    key = '0; nonce = '0; Din = '0;
    repeat (10) @(negedge clk);
    chk("rst_dinack", dinAck, 0);
    chk("rst_doreq", doReq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_dout", Dout, 0);
    start = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    chk("busy_after_rst", busy, 0);

    key = SEQ; nonce = SEQ;
    ad_a[0] = SEQ; ad_a[1] = PAD; tx_a[0] = SEQ; tx_a[1] = PAD;
    run_msg(1'b1, 2, 2, 1'b0, 0, 1'b0, 1'b1);
    ct0 = got_q[0]; ct1 = got_q[1]; tag_e = got_q[2];

    tx_a[0] = ct0; tx_a[1] = ct1;
    run_msg(1'b0, 2, 2, 1'b1, 5, 1'b1, 1'b0);
    chk("rt_pt0", got_q[0], SEQ);
    chk("rt_pt1", got_q[1], PAD);
    chk("rt_tag", got_q[2], tag_e);

    tx_a[0] = {$urandom, $urandom, $urandom, $urandom};
    run_msg(1'b1, 0, 1, 1'b0, 0, 1'b0, 1'b1);

    @(negedge clk); encrypt = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_doreq", doReq, 0);
    chk("midrst_dout", Dout, 0);
    rstn = 1'b1;
    @(negedge clk);
    ad_a[0] = {$urandom, $urandom, $urandom, $urandom};
    run_msg(1'b1, 1, 1, 1'b0, 0, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      key   = {$urandom, $urandom, $urandom, $urandom};
      nonce = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 8; i++) begin
        ad_a[i] = {$urandom, $urandom, $urandom, $urandom};
        tx_a[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      run_msg(1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3, 1)),
              1'($urandom_range(1)), int'($urandom_range(3)), 1'($urandom_range(1)),
              1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
